// File: rtl/ps2_event_queue_if.sv
// Event output handshake between the PS/2 event queue and its consumer.
// master drives the head event and valid; slave returns ready.
// A pop happens on any cycle with ev_valid && ev_ready.
interface ps2_event_queue_if;
  logic [8:0] ev_code;
  logic       ev_break;
  logic       ev_valid;
  logic       ev_ready;

  modport master (output ev_code, output ev_break, output ev_valid, input ev_ready);
  modport slave  (input ev_code, input ev_break, input ev_valid, output ev_ready);
endinterface

// File: rtl/ps2_event_queue.sv
// PS/2 scan-byte parser feeding a key bitmap and a first-word-fall-through event FIFO.
// Latency: byte completing an event at cycle N shows in key_down/FIFO at N+1.
// Backpressure: none toward the byte source; a full FIFO drops events and sets overflow.
module ps2_event_queue #(
  parameter int DEPTH          = 8,
  parameter int FILTER_REPEAT  = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  ps2_event_queue_if.master        ev,
  output logic [511:0]             key_down,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   to_cnt;
  logic            to_hit;
  logic            is_ign;
  logic            ev_fire;
  logic [8:0]      ev_new_code;
  logic            ev_new_brk;
  logic            kd_clear;
  logic            push, pop, full, wr_en, ev_valid_i;
  logic [9:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [9:0]      head, last_pop;

  assign is_ign = byte_in inside {8'h00, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  // A stale prefix is abandoned only on a cycle without a byte; a byte always wins.
  assign to_hit = (state != S_IDLE) && (to_cnt == TO_LAST);

  // Parser state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Parser next state: E0 restarts a prefix, F0 adds break, other codes finish.
  always_comb begin
    state_nxt = state;
    if (byte_valid && !is_ign) begin
      if (byte_in == 8'hE0) begin
        state_nxt = S_EXT;
      end else if (byte_in == 8'hF0) begin
        case (state)
          S_IDLE:  state_nxt = S_BRK;
          S_EXT:   state_nxt = S_EXT_BRK;
          default: state_nxt = state;
        endcase
      end else begin
        state_nxt = S_IDLE;
      end
    end else if (!byte_valid && to_hit) begin
      state_nxt = S_IDLE;
    end
  end

  // Parser outputs: completed event, or a bitmap wipe for AA seen with no prefix.
  always_comb begin
    ev_fire     = 1'b0;
    ev_new_code = 9'd0;
    ev_new_brk  = 1'b0;
    kd_clear    = 1'b0;
    if (byte_valid && !is_ign && byte_in != 8'hE0 && byte_in != 8'hF0) begin
      if (state == S_IDLE && byte_in == 8'hAA) begin
        kd_clear = 1'b1;
      end else begin
        ev_fire     = 1'b1;
        ev_new_code = {(state == S_EXT || state == S_EXT_BRK), byte_in};
        ev_new_brk  = (state == S_BRK || state == S_EXT_BRK);
      end
    end
  end

  // Idle counter for abandoning a half-received prefix.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         to_cnt <= '0;
    else if (byte_valid || state == S_IDLE || to_hit) to_cnt <= '0;
    else                                             to_cnt <= to_cnt + 1'b1;
  end

  // Live key bitmap; updated even when the event itself is dropped or filtered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          key_down <= '0;
    else if (kd_clear) key_down <= '0;
    else if (ev_fire) key_down[ev_new_code] <= !ev_new_brk;
  end

  // Typematic repeats of an already-held key are not queued when filtering.
  assign push       = ev_fire && (ev_new_brk || !((FILTER_REPEAT != 0) && key_down[ev_new_code]));
  assign ev_valid_i = (fifo_level != '0);
  assign pop        = ev_valid_i && ev.ev_ready;
  assign full       = (fifo_level == FULL_LVL);
  assign wr_en      = push && (!full || pop);
  assign head       = mem[rd_ptr];

  // Event storage; slot contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ev_new_brk, ev_new_code};
  end

  // Pointers, level and the held copy of the last popped entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      last_pop   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_pop <= head;
      end
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky overflow; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       overflow <= 1'b0;
    else if (push && full && !pop) overflow <= 1'b1;
    else if (clr_overflow)         overflow <= 1'b0;
  end

  assign ev.ev_valid = ev_valid_i;
  assign ev.ev_code  = ev_valid_i ? head[8:0] : last_pop[8:0];
  assign ev.ev_break = ev_valid_i ? head[9]   : last_pop[9];

endmodule

// File: tb/tb_ps2_event_queue.sv
// Drives two queues (repeat filter on / off) with one byte stream and checks both
// against a queue-based reference every cycle, plus literal spot checks.
// All stimulus changes on the falling edge; outputs are sampled 2 time units after the rising edge.
module tb_ps2_event_queue;
  localparam int DEPTH = 8;
  localparam int TO    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       ev_ready = 1'b0;
  logic       clr_overflow = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]   code_w [2];
  logic         brk_w  [2];
  logic         vld_w  [2];
  logic         ovf_w  [2];
  logic [3:0]   lvl_w  [2];
  logic [511:0] kd_w   [2];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam bit FILT = (g == 0);
    ps2_event_queue_if ev_if ();
    logic [3:0]   lvl;
    logic [511:0] kd;
    logic         ovf;

    ps2_event_queue #(.DEPTH(DEPTH), .FILTER_REPEAT(FILT ? 1 : 0), .TIMEOUT_CYCLES(TO)) u_dut (
      .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .ev(ev_if.master),
      .key_down(kd), .fifo_level(lvl), .overflow(ovf), .clr_overflow(clr_overflow)
    );

    assign ev_if.ev_ready = ev_ready;
    assign code_w[g] = ev_if.ev_code;
    assign brk_w[g]  = ev_if.ev_break;
    assign vld_w[g]  = ev_if.ev_valid;
    assign ovf_w[g]  = ovf;
    assign lvl_w[g]  = lvl;
    assign kd_w[g]   = kd;

    // Reference: pending prefix as two flags, events as {break, code} in a queue.
    logic [9:0]   m_q [$];
    logic [9:0]   m_last = '0;
    logic [511:0] m_keys = '0;
    logic         m_ovf = 1'b0, m_ext = 1'b0, m_brk = 1'b0;
    int           m_quiet = 0;
    logic         e_vld = 1'b0, e_brk = 1'b0;
    logic [8:0]   e_code = '0;
    logic [3:0]   e_lvl = '0;

    task automatic mstep();
      logic       fire, b, keep, pop, was_full;
      logic [8:0] c;
      fire = 1'b0; b = 1'b0; c = '0;
      if (rst) begin
        m_q.delete(); m_last = '0; m_keys = '0; m_ovf = 1'b0;
        m_ext = 1'b0; m_brk = 1'b0; m_quiet = 0;
      end else begin
        pop      = (m_q.size() != 0) && ev_ready;
        was_full = (m_q.size() == DEPTH);
        if (byte_valid) begin
          m_quiet = 0;
          if (byte_in inside {8'h00, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
          end else if (byte_in == 8'hE0) begin
            m_ext = 1'b1; m_brk = 1'b0;
          end else if (byte_in == 8'hF0) begin
            m_brk = 1'b1;
          end else if (byte_in == 8'hAA && !m_ext && !m_brk) begin
            m_keys = '0;
          end else begin
            fire = 1'b1; c = {m_ext, byte_in}; b = m_brk;
            m_ext = 1'b0; m_brk = 1'b0;
          end
        end else if (m_ext || m_brk) begin
          m_quiet++;
          if (m_quiet == TO) begin
            m_ext = 1'b0; m_brk = 1'b0; m_quiet = 0;
          end
        end
        keep = fire && (b || !(FILT && m_keys[c]));
        if (fire) m_keys[c] = !b;
        if (pop) m_last = m_q.pop_front();
        if (keep && was_full && !pop) m_ovf = 1'b1;
        else begin
          if (keep) m_q.push_back({b, c});
          if (clr_overflow) m_ovf = 1'b0;
        end
      end
      e_vld  = (m_q.size() != 0);
      e_lvl  = 4'(m_q.size());
      e_code = e_vld ? m_q[0][8:0] : m_last[8:0];
      e_brk  = e_vld ? m_q[0][9]   : m_last[9];
    endtask

    initial forever begin
      @(posedge clk);
      mstep();
    end
  end

  task automatic cmp_one(input string t, input logic av, input logic ev, input logic [3:0] al,
                         input logic [3:0] el, input logic [8:0] ac, input logic [8:0] ec,
                         input logic ab, input logic eb, input logic ao, input logic eo,
                         input logic [511:0] ak, input logic [511:0] ek);
    chk({t, "_valid"}, av, ev);
    chk({t, "_level"}, al, el);
    chk({t, "_code"},  ac, ec);
    chk({t, "_break"}, ab, eb);
    chk({t, "_ovf"},   ao, eo);
    chk({t, "_keys"},  ak, ek);
  endtask

  // Cycle-by-cycle comparison of both queues against the reference.
  initial forever begin
    @(posedge clk);
    #2;
    cmp_one("m0", vld_w[0], g_inst[0].e_vld, lvl_w[0], g_inst[0].e_lvl, code_w[0], g_inst[0].e_code,
            brk_w[0], g_inst[0].e_brk, ovf_w[0], g_inst[0].m_ovf, kd_w[0], g_inst[0].m_keys);
    cmp_one("m1", vld_w[1], g_inst[1].e_vld, lvl_w[1], g_inst[1].e_lvl, code_w[1], g_inst[1].e_code,
            brk_w[1], g_inst[1].e_brk, ovf_w[1], g_inst[1].m_ovf, kd_w[1], g_inst[1].m_keys);
  end

  task automatic step(input logic v, input logic [7:0] b, input logic r);
    @(negedge clk);
    byte_valid = v; byte_in = b; ev_ready = r;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic pop1();
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; byte_valid = 1'b0; ev_ready = 1'b0; clr_overflow = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] misc_seq [16] = '{8'hE0, 8'hFA, 8'h75, 8'hF0, 8'hF0, 8'hEE, 8'h1C, 8'hE0,
                                8'hF0, 8'hE0, 8'h6B, 8'hFF, 8'h00, 8'hFE, 8'hE0, 8'hAA};

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_valid", vld_w[0], 1'b0);
    chk("reset_level", lvl_w[0], 4'd0);
    chk("reset_code",  code_w[0], 9'h000);

    // Make then break of 1C with no consumer.
    send(8'h1C);
    chk("make_keybit", kd_w[0][9'h01C], 1'b1);
    send(8'hF0); send(8'h1C);
    chk("mkbrk_level", lvl_w[0], 4'd2);
    chk("mkbrk_keybit", kd_w[0][9'h01C], 1'b0);
    chk("mkbrk_head_code", code_w[0], 9'h01C);
    chk("mkbrk_head_brk", brk_w[0], 1'b0);
    pop1();
    chk("pop_head_brk", brk_w[0], 1'b1);
    pop1();
    chk("empty_valid", vld_w[0], 1'b0);
    chk("empty_hold_code", code_w[0], 9'h01C);
    chk("empty_hold_brk", brk_w[0], 1'b1);

    // Extended key with typematic repeats.
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h75); send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("rep_filt_level", lvl_w[0], 4'd2);
    chk("rep_nofilt_level", lvl_w[1], 4'd4);
    chk("rep_head_code", code_w[0], 9'h175);
    pop1();
    chk("rep_second_brk", brk_w[0], 1'b1);

    // Nine distinct makes into an eight-deep queue.
    do_reset();
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
    chk("ovf_level", lvl_w[0], 4'd8);
    chk("ovf_flag", ovf_w[0], 1'b1);
    chk("ovf_keycount", $countones(kd_w[0]), 9);
    @(negedge clk); clr_overflow = 1'b1;
    @(negedge clk); clr_overflow = 1'b0;
    chk("ovf_cleared", ovf_w[0], 1'b0);

    // Push and pop together while full.
    step(1'b1, 8'h19, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("fullpp_level", lvl_w[0], 4'd8);
    chk("fullpp_ovf", ovf_w[0], 1'b0);
    chk("fullpp_head", code_w[0], 9'h011);
    repeat (10) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("drain_last", code_w[0], 9'h019);

    // AA self-test clears held keys, then reset with entries queued and a prefix pending.
    do_reset();
    send(8'h1C); send(8'h29); send(8'hAA);
    chk("aa_keys", kd_w[0], 512'd0);
    chk("aa_level", lvl_w[0], 4'd2);
    send(8'h05); send(8'hE0);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst_async_valid", vld_w[0], 1'b0);
    chk("rst_async_level", lvl_w[1], 4'd0);
    @(negedge clk); rst = 1'b0;
    send(8'h75);
    chk("rst_prefix_lost", code_w[0], 9'h075);

    // Prefix timeout versus a byte landing in the timeout cycle.
    do_reset();
    send(8'hF0); idle(19); send(8'h29);
    chk("to_code", code_w[0], 9'h029);
    chk("to_make", brk_w[0], 1'b0);
    send(8'hF0); idle(14); send(8'h29);
    chk("to_edge_level", lvl_w[0], 4'd2);
    chk("to_edge_keybit", kd_w[0][9'h029], 1'b0);
    pop1();
    chk("to_edge_brk", brk_w[0], 1'b1);

    // Ignored bytes, prefix restart and AA as an extended code.
    do_reset();
    foreach (misc_seq[i]) send(misc_seq[i]);
    send(8'hAA);
    chk("misc_level", lvl_w[0], 4'd4);
    chk("misc_keys", kd_w[0], 512'd0);
    repeat (6) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("misc_last", code_w[0], 9'h1AA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
